ssd1306_spi_responder: RTL

- Device-side model of the 4-wire SPI OLED interface: receives the SCLK/SDIN/CS/DC/RES pins that the OLED driver produces and reassembles them into command and data bytes.
- Decodes the SSD1306 command subset the driver emits, tracks column/page addressing, and emits framebuffer write strobes.
- Used as a loopback checker on-fabric and as the bench-side responder for the OLED driver.

---
 rtl/ssd1306_spi_responder_pkg.sv | 30 +++
 rtl/ssd1306_spi_responder_spi_byte_rx.sv | 99 +++++++++
 rtl/ssd1306_spi_responder.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/ssd1306_spi_responder_pkg.sv
// ssd1306_pkg: shared definitions for the SSD1306 SPI responder.
//   - opcode constants for the commands the OLED driver emits
//   - decoder state enum
//   - arg_count(): number of argument bytes that follow a command opcode
// Used together with the optional error-reporting build flag SSD1306_RESP_ERR_EN
// (see ssd1306_spi_responder.sv); the package itself has no configuration.
package ssd1306_pkg;

    localparam logic [7:0] DISPLAY_OFF   = 8'hAE;
    localparam logic [7:0] DISPLAY_ON    = 8'hAF;
    localparam logic [7:0] SET_COL_ADDR  = 8'h21;
    localparam logic [7:0] SET_PAGE_ADDR = 8'h22;

    typedef enum logic [1:0] {
        CMD  = 2'd0,
        ARG  = 2'd1,
        SKIP = 2'd2
    } dec_state_e;

    // Argument bytes following a command; anything not listed takes none.
    function automatic logic [1:0] arg_count(input logic [7:0] op);
        case (op)
            SET_COL_ADDR, SET_PAGE_ADDR:        arg_count = 2'd2;
            8'h20, 8'h81, 8'h8D, 8'hA8, 8'hD3,
            8'hD5, 8'hD9, 8'hDA, 8'hDB:         arg_count = 2'd1;
            default:                            arg_count = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/ssd1306_spi_responder_spi_byte_rx.sv
// spi_byte_rx: pin front end of the SSD1306 SPI responder.
//   Synchronizes the five asynchronous pins, detects SCLK rising edges,
//   shifts SDIN in MSB first and reports each completed byte.
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   sclk_i .. res_i     raw OLED interface pins (asynchronous)
//   pin_reset           synchronized res_i is low (acts as a reset downstream)
//   rx_valid            one-cycle pulse: rx_byte / rx_dc hold a completed byte
//   rx_abort            (SSD1306_RESP_ERR_EN only) CS rose with a partial byte
module spi_byte_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sclk_i,
    input  logic       sdin_i,
    input  logic       cs_i,
    input  logic       dc_i,
    input  logic       res_i,
    output logic       pin_reset,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       rx_dc
`ifdef SSD1306_RESP_ERR_EN
    ,
    output logic       rx_abort
`endif
);

    logic [SYNC_STAGES-1:0] sclk_sync, sdin_sync, cs_sync, dc_sync, res_sync;
    logic       sclk_last;
    logic       rise_q, sdin_q, dc_q;
    logic [2:0] bit_cnt;
    logic [6:0] shreg;
    logic       cs_high;

    assign cs_high   = cs_sync[SYNC_STAGES-1];
    assign pin_reset = ~res_sync[SYNC_STAGES-1];

    // NOTE: the synchronizers answer only to the system reset; if res_i cleared
    // them, the synchronized res_i could never return high again.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync <= '0;
            sdin_sync <= '0;
            cs_sync   <= '1;
            dc_sync   <= '0;
            res_sync  <= '1;
            sclk_last <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
            sdin_sync <= {sdin_sync[SYNC_STAGES-2:0], sdin_i};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_i};
            dc_sync   <= {dc_sync[SYNC_STAGES-2:0], dc_i};
            res_sync  <= {res_sync[SYNC_STAGES-2:0], res_i};
            sclk_last <= sclk_sync[SYNC_STAGES-1];
        end
    end

    // The detected rise is registered together with the SDIN/DC samples taken
    // at that rise, so the shift acts on data seen at the edge itself.
    // NOTE: non-blocking assignments everywhere in clocked logic, so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset || pin_reset) begin
            rise_q   <= 1'b0;
            sdin_q   <= 1'b0;
            dc_q     <= 1'b0;
            bit_cnt  <= 3'd0;
            shreg    <= 7'd0;
            rx_valid <= 1'b0;
            rx_byte  <= 8'd0;
            rx_dc    <= 1'b0;
        end else begin
            rise_q   <= sclk_sync[SYNC_STAGES-1] & ~sclk_last;
            sdin_q   <= sdin_sync[SYNC_STAGES-1];
            dc_q     <= dc_sync[SYNC_STAGES-1];
            rx_valid <= 1'b0;
            if (cs_high) begin
                // Drops any partial byte, including one completing this cycle.
                bit_cnt <= 3'd0;
            end else if (rise_q) begin
                shreg   <= {shreg[5:0], sdin_q};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    rx_valid <= 1'b1;
                    rx_byte  <= {shreg, sdin_q};
                    rx_dc    <= dc_q;
                end
            end
        end
    end

`ifdef SSD1306_RESP_ERR_EN
    // The counter is cleared on the first CS-high cycle, so this is one pulse.
    assign rx_abort = cs_high & (bit_cnt != 3'd0) & ~pin_reset;
`endif

endmodule

// File: rtl/ssd1306_spi_responder.sv
// ssd1306_spi_responder: device-side model of the SSD1306 4-wire SPI interface.
//   Reassembles bytes from the pins, decodes the command subset (display
//   on/off, column/page windows, 1-arg commands skipped) and issues
//   framebuffer writes in horizontal addressing mode.
// Ports:
//   clk, reset                system clock, synchronous active-high reset
//   sclk_i, sdin_i, cs_i,     OLED SPI pins (asynchronous)
//   dc_i, res_i
//   byte_valid_o/byte_o/      completed byte and its DC value
//   byte_is_data_o
//   fb_we_o/fb_addr_o/        framebuffer write strobe, page*COLS+col, data
//   fb_wdata_o
//   display_on_o              set by 0xAF, cleared by 0xAE
//   err_o, err_cnt_o          only with SSD1306_RESP_ERR_EN defined: sticky
//                             error flag and saturating error count
module ssd1306_spi_responder
    import ssd1306_pkg::*;
#(
    parameter int COLS        = 128,
    parameter int PAGES       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           sclk_i,
    input  logic                           sdin_i,
    input  logic                           cs_i,
    input  logic                           dc_i,
    input  logic                           res_i,
    output logic                           byte_valid_o,
    output logic [7:0]                     byte_o,
    output logic                           byte_is_data_o,
    output logic                           fb_we_o,
    output logic [$clog2(COLS*PAGES)-1:0]  fb_addr_o,
    output logic [7:0]                     fb_wdata_o,
    output logic                           display_on_o
`ifdef SSD1306_RESP_ERR_EN
    ,
    output logic                           err_o,
    output logic [7:0]                     err_cnt_o
`endif
);

    localparam int CW = $clog2(COLS);
    localparam int PW = $clog2(PAGES);

    logic       pin_reset, rx_valid, rx_dc;
    logic [7:0] rx_byte;
`ifdef SSD1306_RESP_ERR_EN
    logic       rx_abort, err_evt;
`endif

    spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
        .clk       (clk),
        .reset     (reset),
        .sclk_i    (sclk_i),
        .sdin_i    (sdin_i),
        .cs_i      (cs_i),
        .dc_i      (dc_i),
        .res_i     (res_i),
        .pin_reset (pin_reset),
        .rx_valid  (rx_valid),
        .rx_byte   (rx_byte),
        .rx_dc     (rx_dc)
`ifdef SSD1306_RESP_ERR_EN
        ,
        .rx_abort  (rx_abort)
`endif
    );

    dec_state_e    state_q, state_d;
    logic [1:0]    args_q, args_d;
    logic          tgt_page_q, tgt_page_d;
    logic [CW-1:0] col_start_q, col_start_d, col_end_q, col_end_d, col_q, col_d;
    logic [PW-1:0] page_start_q, page_start_d, page_end_q, page_end_d, page_q, page_d;
    logic          disp_d, we_d;
    logic [CW+PW-1:0] addr_d;
    logic [7:0]    wdata_d;

    // Decoder acts on the registered byte, so fb_we_o trails byte_valid_o by one.
    // NOTE: every signal written here gets a default first; a path that skips
    // an assignment would otherwise infer a latch.
    always_comb begin
        state_d      = state_q;
        args_d       = args_q;
        tgt_page_d   = tgt_page_q;
        col_start_d  = col_start_q;
        col_end_d    = col_end_q;
        page_start_d = page_start_q;
        page_end_d   = page_end_q;
        col_d        = col_q;
        page_d       = page_q;
        disp_d       = display_on_o;
        we_d         = 1'b0;
        addr_d       = fb_addr_o;
        wdata_d      = fb_wdata_o;
`ifdef SSD1306_RESP_ERR_EN
        err_evt      = 1'b0;
`endif
        if (byte_valid_o) begin
            if (byte_is_data_o) begin
                // Pixel data always writes; a pending argument list is dropped.
`ifdef SSD1306_RESP_ERR_EN
                err_evt = (state_q != CMD);
`endif
                state_d = CMD;
                args_d  = 2'd0;
                we_d    = 1'b1;
                addr_d  = {page_q, col_q};
                wdata_d = byte_o;
                // Pointers wrap through the field maximum when start > end.
                if (col_q == col_end_q) begin
                    col_d  = col_start_q;
                    page_d = (page_q == page_end_q) ? page_start_q : page_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end else begin
                unique case (state_q)
                    CMD: begin
                        if (byte_o == DISPLAY_ON) begin
                            disp_d = 1'b1;
                        end else if (byte_o == DISPLAY_OFF) begin
                            disp_d = 1'b0;
                        end else if (arg_count(byte_o) == 2'd2) begin
                            state_d    = ARG;
                            args_d     = 2'd2;
                            tgt_page_d = (byte_o == SET_PAGE_ADDR);
                        end else if (arg_count(byte_o) != 2'd0) begin
                            state_d = SKIP;
                            args_d  = arg_count(byte_o);
                        end
                    end
                    ARG: begin
                        if (args_q == 2'd2) begin
                            args_d = 2'd1;
                            if (tgt_page_q) page_start_d = byte_o[PW-1:0];
                            else            col_start_d  = byte_o[CW-1:0];
                        end else begin
                            state_d = CMD;
                            args_d  = 2'd0;
                            if (tgt_page_q) begin
                                page_end_d = byte_o[PW-1:0];
                                page_d     = page_start_q;
                            end else begin
                                col_end_d = byte_o[CW-1:0];
                                col_d     = col_start_q;
                            end
                        end
                    end
                    SKIP: begin
                        args_d = args_q - 2'd1;
                        if (args_q == 2'd1) state_d = CMD;
                    end
                    default: state_d = CMD;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || pin_reset) begin
            byte_valid_o   <= 1'b0;
            byte_o         <= 8'd0;
            byte_is_data_o <= 1'b0;
            state_q        <= CMD;
            args_q         <= 2'd0;
            tgt_page_q     <= 1'b0;
            col_start_q    <= '0;
            col_end_q      <= CW'(COLS - 1);
            page_start_q   <= '0;
            page_end_q     <= PW'(PAGES - 1);
            col_q          <= '0;
            page_q         <= '0;
            display_on_o   <= 1'b0;
            fb_we_o        <= 1'b0;
            fb_addr_o      <= '0;
            fb_wdata_o     <= 8'd0;
        end else begin
            byte_valid_o   <= rx_valid;
            if (rx_valid) begin
                byte_o         <= rx_byte;
                byte_is_data_o <= rx_dc;
            end
            state_q        <= state_d;
            args_q         <= args_d;
            tgt_page_q     <= tgt_page_d;
            col_start_q    <= col_start_d;
            col_end_q      <= col_end_d;
            page_start_q   <= page_start_d;
            page_end_q     <= page_end_d;
            col_q          <= col_d;
            page_q         <= page_d;
            display_on_o   <= disp_d;
            fb_we_o        <= we_d;
            fb_addr_o      <= addr_d;
            fb_wdata_o     <= wdata_d;
        end
    end

`ifdef SSD1306_RESP_ERR_EN
    always_ff @(posedge clk) begin
        if (reset || pin_reset) begin
            err_o     <= 1'b0;
            err_cnt_o <= 8'd0;
        end else if (rx_abort || err_evt) begin
            err_o <= 1'b1;
            if (err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
        end
    end
`endif

endmodule
